sgnmag_bcd_conv: RTL and testbench

// - Sequential binary-to-BCD converter, downstream of conv_sgnmag.
// - Takes the sign/magnitude form of the x10 temperature value and

---
 rtl/sgnmag_bcd_conv.sv | 167 ++++++++++++++++
 tb/tb_sgnmag_bcd_conv.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sgnmag_bcd_conv.sv
// sgnmag_bcd_conv
// Sequential binary-to-BCD converter for the x10 temperature value. Takes the
// sign/magnitude form from conv_sgnmag and produces packed BCD digits plus a
// sign flag for the seven-segment stage. Double dabble, one magnitude bit per
// clock, start/done handshake.
//
// Optional build macro: SGNMAG_BCD_BLANK_EN enables the leading-zero blank mask
// (digits >= 2 only). Without it, blank is tied to zero.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   conversion request, sampled only in IDLE
//   tx10_sign  in   1 = negative
//   tx10_mag   in   [MAG_W-1:0] unsigned magnitude in tenths
//   busy       out  high while converting
//   done       out  one-cycle pulse, results valid from this cycle on
//   sign_out   out  sign of the last completed conversion (negative zero -> 0)
//   bcd        out  [4*NDIG-1:0] packed digits, [3:0] = tenths
//   blank      out  [NDIG-1:0] leading-zero blank mask
//
// state  | meaning
// IDLE   | waiting for start
// CONV   | one add-3/shift step per cycle, MAG_W cycles
// DONE   | results presented, done pulse
module sgnmag_bcd_conv #(
  parameter int MAG_W = 17,
  parameter int NDIG  = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                tx10_sign,
  input  logic [MAG_W-1:0]    tx10_mag,
  output logic                busy,
  output logic                done,
  output logic                sign_out,
  output logic [4*NDIG-1:0]   bcd,
  output logic [NDIG-1:0]     blank
);

  localparam int BW    = 4 * NDIG;
  localparam int CNT_W = $clog2(MAG_W + 1);

  // The digit count must cover the largest magnitude.
  if (64'(10) ** NDIG <= (64'd1 << MAG_W) - 64'd1) begin : g_ndig_chk
    $error("sgnmag_bcd_conv: NDIG too small for MAG_W");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [MAG_W-1:0]  sh_q, sh_d;
  logic [BW-1:0]     scr_q, scr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic              sign_out_q, sign_out_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [BW-1:0]     scr_adj;
  logic [BW-1:0]     scr_shift;

`ifdef SGNMAG_BCD_BLANK_EN
  logic [NDIG-1:0]   blank_q, blank_d;

  // Blank leading zero digits from the MSD down to digit 2; "0.0" always shows.
  function automatic logic [NDIG-1:0] lz_blank(input logic [BW-1:0] v);
    logic [NDIG-1:0] m;
    logic            run;
    m   = '0;
    run = 1'b1;
    for (int i = NDIG - 1; i >= 2; i--) begin
      if (v[4*i +: 4] != 4'd0) run = 1'b0;
      m[i] = run;
    end
    return m;
  endfunction
`endif

  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < NDIG; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
    scr_shift = {scr_adj[BW-2:0], sh_q[MAG_W-1]};
  end

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    sign_out_d = sign_out_q;
    bcd_d      = bcd_q;
`ifdef SGNMAG_BCD_BLANK_EN
    blank_d    = blank_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_d    = tx10_mag;
          sign_d  = tx10_sign & (|tx10_mag);
          scr_d   = '0;
          cnt_d   = CNT_W'(MAG_W);
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        sh_d  = sh_q << 1;
        scr_d = scr_shift;
        cnt_d = cnt_q - CNT_W'(1);
        // Results are loaded on the edge into DONE so they are valid with done.
        if (cnt_q == CNT_W'(1)) begin
          state_d    = S_DONE;
          bcd_d      = scr_shift;
          sign_out_d = sign_q;
`ifdef SGNMAG_BCD_BLANK_EN
          blank_d    = lz_blank(scr_shift);
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sh_q       <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      sign_out_q <= 1'b0;
      bcd_q      <= '0;
`ifdef SGNMAG_BCD_BLANK_EN
      blank_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      sign_out_q <= sign_out_d;
      bcd_q      <= bcd_d;
`ifdef SGNMAG_BCD_BLANK_EN
      blank_q    <= blank_d;
`endif
    end
  end

  assign busy     = (state_q == S_CONV);
  assign done     = (state_q == S_DONE);
  assign sign_out = sign_out_q;
  assign bcd      = bcd_q;
`ifdef SGNMAG_BCD_BLANK_EN
  assign blank    = blank_q;
`else
  assign blank    = '0;
`endif

endmodule

// File: tb/tb_sgnmag_bcd_conv.sv
module tb_sgnmag_bcd_conv;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        tx10_sign;
  logic [16:0] tx10_mag;
  logic        busy;
  logic        done;
  logic        sign_out;
  logic [23:0] bcd;
  logic [5:0]  blank;

  int errors = 0;
  int checks = 0;
  int n_pushed = 0;
  int n_done = 0;

  typedef struct {
    logic        s;
    logic [23:0] b;
    logic [5:0]  bl;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;

  sgnmag_bcd_conv #(.MAG_W(17), .NDIG(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .tx10_sign (tx10_sign),
    .tx10_mag  (tx10_mag),
    .busy      (busy),
    .done      (done),
    .sign_out  (sign_out),
    .bcd       (bcd),
    .blank     (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  // Reference model: decimal digits by plain division.
  function automatic logic [23:0] ref_bcd(input int unsigned m);
    logic [23:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'((m / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Digit i (i >= 2) is a leading zero exactly when the value is below 10**i.
  function automatic logic [5:0] ref_blank(input int unsigned m);
    logic [5:0] r;
    int unsigned p;
    r = '0;
`ifdef SGNMAG_BCD_BLANK_EN
    p = 100;
    for (int i = 2; i < 6; i++) begin
      r[i] = (m < p);
      p = p * 10;
    end
`else
    p = 0;
    r = (m < p) ? 6'h3f : 6'h00;
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("bcd", 32'(bcd), 32'(e.b));
        chk("sign_out", 32'(sign_out), 32'(e.s));
        chk("blank", 32'(blank), 32'(e.bl));
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Issue a conversion in the current (IDLE) cycle and wait for done.
  // glitch: cycle index at which a stray start with mag=999 is pulsed.
  // start_in_done: also raise start in the done cycle.
  task automatic run_conv(input logic s, input int unsigned m, input int glitch,
                          input bit start_in_done);
    int lat;
    int bc;
    exp_t e;
    tx10_sign = s;
    tx10_mag  = 17'(m);
    start     = 1'b1;
    e.s  = s && (m != 0);
    e.b  = ref_bcd(m);
    e.bl = ref_blank(m);
    exp_q.push_back(e);
    n_pushed++;
    next();
    start     = 1'b0;
    tx10_mag  = 17'($urandom);
    tx10_sign = 1'($urandom);
    lat = 1;
    bc  = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      start = (lat == glitch);
      if (start) tx10_mag = 17'd999;
      next();
      start = 1'b0;
      lat++;
    end
    chk("latency", 32'(lat), 32'(18));
    chk("busy_cycles", 32'(bc), 32'(17));
    last_exp = e;
    if (start_in_done) begin
      tx10_mag = 17'd4242;
      start = 1'b1;
      next();
      start = 1'b0;
      chk("start_in_done_busy", 32'(busy), 32'(0));
      chk("start_in_done_hold", 32'(bcd), 32'(e.b));
      repeat (3) begin
        next();
        chk("start_in_done_idle", 32'(busy), 32'(0));
      end
    end
  endtask

  task automatic reset_abort(input int unsigned m);
    tx10_sign = 1'b1;
    tx10_mag  = 17'(m);
    start     = 1'b1;
    next();
    start = 1'b0;
    repeat (8) next();
    chk("abort_pre_busy", 32'(busy), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_bcd", 32'(bcd), 32'(0));
    chk("abort_sign", 32'(sign_out), 32'(0));
    chk("abort_blank", 32'(blank), 32'(0));
    next();
    rst_n = 1'b1;
    repeat (25) begin
      next();
      chk("abort_no_done", 32'(done), 32'(0));
    end
    last_exp.s  = 1'b0;
    last_exp.b  = '0;
    last_exp.bl = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    tx10_sign = 1'b0;
    tx10_mag  = '0;
    last_exp.s  = 1'b0;
    last_exp.b  = '0;
    last_exp.bl = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_sign", 32'(sign_out), 32'(0));
    chk("rst_bcd", 32'(bcd), 32'(0));
    chk("rst_blank", 32'(blank), 32'(0));
    rst_n = 1'b1;
    next();

    run_conv(1'b1, 256, -1, 1'b0);     next();
    run_conv(1'b0, 131071, -1, 1'b0);  next();
    run_conv(1'b1, 0, -1, 1'b0);       next();
    run_conv(1'b1, 256, 5, 1'b0);      next();
    run_conv(1'b0, 20, -1, 1'b0);      next();
    run_conv(1'b0, 5, -1, 1'b0);       next();
    run_conv(1'b0, 1234, -1, 1'b1);    next();

    reset_abort(77777);
    run_conv(1'b0, 9876, -1, 1'b0);
    next();
    run_conv(1'b0, 1560, -1, 1'b0);
    next();

    for (int k = 0; k < 40; k++) begin
      int gap;
      int unsigned m;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        chk("hold_bcd", 32'(bcd), 32'(last_exp.b));
        chk("hold_sign", 32'(sign_out), 32'(last_exp.s));
        next();
      end
      m = (k % 5 == 0) ? $urandom_range(0, 120) : $urandom_range(0, 131071);
      run_conv(1'($urandom), m, -1, 1'b0);
      next();
    end

    repeat (5) next();
    chk("queue_empty", 32'(exp_q.size()), 32'(0));
    chk("done_count", 32'(n_done), 32'(n_pushed));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
